// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, taken-branch flushes, halt
// drain/park, and saturating stall/flush event counters for debug.

module pipe_hazard_srcmatch (
  input  logic [4:0] i_rs,
  input  logic       i_use,
  input  logic [4:0] i_rd,
  output logic       o_hit
);
  assign o_hit = i_use & (i_rs == i_rd);
endmodule

module pipe_hazard_satcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge clr)
    if (!clr)                    r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;

  assign o_cnt = r_cnt;
endmodule

module pipe_hazard_ctrl #(
  parameter int DRAIN = 3,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [4:0]    id_rn,
  input  logic [4:0]    id_rm,
  input  logic          id_use_rn,
  input  logic          id_use_rm,
  input  logic          ex_memread,
  input  logic [4:0]    ex_rd,
  input  logic          m_br_taken,
  input  logic          halt_req,
  output logic          pc_en,
  output logic          fd_en,
  output logic          fd_flush,
  output logic          dx_flush,
  output logic          xm_flush,
  output logic          halt_ack,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] flush_cnt
);
  localparam int NSRC = 2;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] DLAST     = 2'(DRAIN - 1);

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic dx_flush;
    logic xm_flush;
    logic halt_ack;
  } ctl_t;

  localparam ctl_t C_RST   = ctl_t'(6'b001110);
  localparam ctl_t C_RUN   = ctl_t'(6'b110000);
  localparam ctl_t C_STALL = ctl_t'(6'b000100);
  localparam ctl_t C_BR    = ctl_t'(6'b111110);
  localparam ctl_t C_DRN   = ctl_t'(6'b011000);
  localparam ctl_t C_HLT   = ctl_t'(6'b001111);

  logic [1:0]            r_state, w_state_nxt;
  logic [1:0]            r_dcnt, w_dcnt_nxt;
  logic [NSRC-1:0][4:0]  w_src;
  logic [NSRC-1:0]       w_use, w_hit;
  logic                  w_lu, w_stall_evt, w_br_evt;
  ctl_t                  w_ctl, w_out;

  assign w_src = {id_rm, id_rn};
  assign w_use = {id_use_rm, id_use_rn};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    pipe_hazard_srcmatch u_match (
      .i_rs  (w_src[g]),
      .i_use (w_use[g]),
      .i_rd  (ex_rd),
      .o_hit (w_hit[g])
    );
  end

  // XZR reads as zero, so a load targeting it never creates a dependency.
  assign w_lu = ex_memread & (ex_rd != 5'd31) & (|w_hit);

  always_comb begin
    w_ctl       = C_RST;
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_stall_evt = 1'b0;
    w_br_evt    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (m_br_taken) begin
          w_ctl    = C_BR;
          w_br_evt = 1'b1;
        end else if (w_lu) begin
          w_ctl       = C_STALL;
          w_stall_evt = 1'b1;
        end else if (halt_req) begin
          // F instruction is discarded here and refetched on resume.
          w_ctl       = C_DRN;
          w_state_nxt = ST_DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_ctl = C_RUN;
        end
      end
      ST_DRAIN: begin
        if (m_br_taken) begin
          w_ctl      = C_BR;
          w_br_evt   = 1'b1;
          w_dcnt_nxt = '0;
        end else begin
          w_ctl      = C_DRN;
          w_dcnt_nxt = r_dcnt + 2'd1;
          if (r_dcnt == DLAST) w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        w_ctl = C_HLT;
        if (!halt_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      r_state <= ST_RUN;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end

  pipe_hazard_satcnt #(.W(CW)) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .i_inc (w_stall_evt),
    .o_cnt (stall_cnt)
  );

  pipe_hazard_satcnt #(.W(CW)) u_flush_cnt (
    .clk   (clk),
    .clr   (clr),
    .i_inc (w_br_evt),
    .o_cnt (flush_cnt)
  );

  // Controls are held in the safe bubble pattern for as long as clr is low.
  assign w_out    = clr ? w_ctl : C_RST;
  assign pc_en    = w_out.pc_en;
  assign fd_en    = w_out.fd_en;
  assign fd_flush = w_out.fd_flush;
  assign dx_flush = w_out.dx_flush;
  assign xm_flush = w_out.xm_flush;
  assign halt_ack = w_out.halt_ack;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: cycle table with hand-derived expectations fed
// through a scoreboard queue, plus reset-in-drain and counter saturation.

module tb_pipe_hazard_ctrl;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          clr;
  logic [4:0]    id_rn, id_rm, ex_rd;
  logic          id_use_rn, id_use_rm, ex_memread, m_br_taken, halt_req;
  logic          pc_en, fd_en, fd_flush, dx_flush, xm_flush, halt_ack;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DRAIN(3), .CW(CW)) dut (
    .clk        (clk),
    .clr        (clr),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_use_rn  (id_use_rn),
    .id_use_rm  (id_use_rm),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .m_br_taken (m_br_taken),
    .halt_req   (halt_req),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .fd_flush   (fd_flush),
    .dx_flush   (dx_flush),
    .xm_flush   (xm_flush),
    .halt_ack   (halt_ack),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // ctl bits: {pc_en, fd_en, fd_flush, dx_flush, xm_flush, halt_ack}
  localparam logic [5:0] RST   = 6'b001110;
  localparam logic [5:0] RUNOK = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] BR    = 6'b111110;
  localparam logic [5:0] DRN   = 6'b011000;
  localparam logic [5:0] HLT   = 6'b001111;

  typedef struct {
    string      name;
    logic [4:0] rn;
    logic       urn;
    logic [4:0] rm;
    logic       urm;
    logic       mrd;
    logic [4:0] rd;
    logic       br;
    logic       hreq;
    logic [5:0] ctl;
    int         s;
    int         f;
  } vec_t;

  vec_t tbl[29];
  vec_t sb[$];

  function automatic vec_t mk(string n, int rn, int urn, int rm, int urm, int mrd,
                              int rd, int br, int hreq, logic [5:0] ctl, int s, int f);
    vec_t v;
    v.name = n; v.rn = 5'(rn); v.urn = 1'(urn); v.rm = 5'(rm); v.urm = 1'(urm);
    v.mrd = 1'(mrd); v.rd = 5'(rd); v.br = 1'(br); v.hreq = 1'(hreq);
    v.ctl = ctl; v.s = s; v.f = f;
    return v;
  endfunction

  function automatic logic [5:0] ctl_now();
    return {pc_en, fd_en, fd_flush, dx_flush, xm_flush, halt_ack};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    id_rn = v.rn; id_use_rn = v.urn; id_rm = v.rm; id_use_rm = v.urm;
    ex_memread = v.mrd; ex_rd = v.rd; m_br_taken = v.br; halt_req = v.hreq;
  endtask

  // Drive one cycle's inputs, queue its expectation, compare mid-cycle.
  task automatic step(vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.name, "_ctl"},   32'(ctl_now()), 32'(e.ctl));
    chk({e.name, "_stall"}, 32'(stall_cnt), 32'(e.s));
    chk({e.name, "_flush"}, 32'(flush_cnt), 32'(e.f));
    @(posedge clk); #1;
  endtask

  initial begin
    //            name          rn urn rm urm mrd rd br hq ctl    s f
    tbl[0]  = mk("idle",         0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 0, 0);
    tbl[1]  = mk("lu_rn",        1, 1, 3, 1, 1, 1, 0, 0, STALL, 0, 0);
    tbl[2]  = mk("post_lu",      1, 1, 3, 1, 0, 0, 0, 0, RUNOK, 1, 0);
    tbl[3]  = mk("lu_rm",        0, 1, 7, 1, 1, 7, 0, 0, STALL, 1, 0);
    tbl[4]  = mk("rm_unused",    0, 1, 7, 0, 1, 7, 0, 0, RUNOK, 2, 0);
    tbl[5]  = mk("xzr",         31, 1,31, 1, 1,31, 0, 0, RUNOK, 2, 0);
    tbl[6]  = mk("no_load",      4, 1, 4, 1, 0, 4, 0, 0, RUNOK, 2, 0);
    tbl[7]  = mk("br_lu",        3, 1, 0, 0, 1, 3, 1, 0, BR,    2, 0);
    tbl[8]  = mk("post_br",      0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 2, 1);
    tbl[9]  = mk("br",           0, 0, 0, 0, 0, 0, 1, 0, BR,    2, 1);
    tbl[10] = mk("halt_req",     0, 0, 0, 0, 0, 0, 0, 1, DRN,   2, 2);
    tbl[11] = mk("drain1",       0, 0, 0, 0, 0, 0, 0, 1, DRN,   2, 2);
    tbl[12] = mk("drain2_drop",  0, 0, 0, 0, 0, 0, 0, 0, DRN,   2, 2);
    tbl[13] = mk("drain3",       0, 0, 0, 0, 0, 0, 0, 1, DRN,   2, 2);
    tbl[14] = mk("halted",       0, 0, 0, 0, 0, 0, 0, 1, HLT,   2, 2);
    tbl[15] = mk("halted_lu",    2, 1, 0, 0, 1, 2, 0, 1, HLT,   2, 2);
    tbl[16] = mk("release",      0, 0, 0, 0, 0, 0, 0, 0, HLT,   2, 2);
    tbl[17] = mk("resume",       0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 2, 2);
    tbl[18] = mk("lu_halt",      5, 1, 0, 0, 1, 5, 0, 1, STALL, 2, 2);
    tbl[19] = mk("halt_post_lu", 0, 0, 0, 0, 0, 0, 0, 1, DRN,   3, 2);
    tbl[20] = mk("br_drain",     0, 0, 0, 0, 0, 0, 1, 1, BR,    3, 2);
    tbl[21] = mk("drain_r1",     0, 0, 0, 0, 0, 0, 0, 1, DRN,   3, 3);
    tbl[22] = mk("drain_r2",     0, 0, 0, 0, 0, 0, 0, 1, DRN,   3, 3);
    tbl[23] = mk("drain_r3",     0, 0, 0, 0, 0, 0, 0, 1, DRN,   3, 3);
    tbl[24] = mk("halted2",      0, 0, 0, 0, 0, 0, 0, 1, HLT,   3, 3);
    tbl[25] = mk("release2",     0, 0, 0, 0, 0, 0, 0, 0, HLT,   3, 3);
    tbl[26] = mk("resume2",      0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 3, 3);
    tbl[27] = mk("br_halt",      0, 0, 0, 0, 0, 0, 1, 1, BR,    3, 3);
    tbl[28] = mk("post_br_halt", 0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 3, 4);

    // Reset held: forced bubble outputs, counters cleared.
    clr = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl",   32'(ctl_now()), 32'(RST));
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 29; i++) step(tbl[i]);

    // Asynchronous reset while draining.
    step(mk("clr_halt", 0, 0, 0, 0, 0, 0, 0, 1, DRN, 3, 4));
    clr = 1'b0;
    #1;
    chk("clr_drain_ctl",   32'(ctl_now()), 32'(RST));
    chk("clr_drain_stall", 32'(stall_cnt), 32'd0);
    chk("clr_drain_flush", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    halt_req = 1'b0;
    @(posedge clk); #1;
    step(mk("post_clr", 0, 0, 0, 0, 0, 0, 0, 0, RUNOK, 0, 0));

    // Continuous load-use hazard to saturate stall_cnt.
    drive(mk("sat", 9, 1, 0, 0, 1, 9, 0, 0, STALL, 0, 0));
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(stall_cnt), 32'h0000fffe);
    @(posedge clk); #1;
    chk("sat_ffff", 32'(stall_cnt), 32'h0000ffff);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_hold",  32'(stall_cnt), 32'h0000ffff);
    chk("sat_ctl",   32'(ctl_now()), 32'(STALL));
    chk("sat_flush", 32'(flush_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
